// File: rtl/debug_irq_controller.sv
// Avalon-MM interrupt controller: synchronised edge capture, pending/mask registers,
// fixed-priority arbitration and a req/ack/EOI handshake with the core.
module debug_irq_controller #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq_req,
  output logic [4:0]       irq_id,
  input  logic             irq_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam logic [N_SRC-1:0] SRC_ONE  = N_SRC'(1'b1);
  localparam logic [N_SRC-1:0] SRC_ZERO = N_SRC'(1'b0);

  logic [N_SRC-1:0] sync1_r;
  logic [N_SRC-1:0] sync2_r;
  logic [N_SRC-1:0] prev_r;
  logic [N_SRC-1:0] edge_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [1:0]       state_r;

  logic             wr_s;
  logic [N_SRC-1:0] eligible_s;
  logic [N_SRC-1:0] id_onehot_s;
  logic             id_eligible_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] pending_next_s;
  logic [1:0]       state_next_s;
  logic [4:0]       irq_id_next_s;
  logic [31:0]      rd_s;

  // Lowest set index wins; bit 0 has the highest priority.
  function automatic logic [4:0] lowest_index(input logic [N_SRC-1:0] v);
    logic [4:0] w;
    w = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        w = 5'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Zero-extend a source vector to the 32-bit register width.
  function automatic logic [31:0] pad32(input logic [N_SRC-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[N_SRC-1:0] = v;
    return r;
  endfunction

  assign wr_s          = chipselect & write;
  assign eligible_s    = pending_r & mask_r;
  assign id_onehot_s   = SRC_ONE << irq_id;
  assign id_eligible_s = |(eligible_s & id_onehot_s);

  // Pending update: software W1C and ack clears, with edge set taking precedence.
  always_comb begin
    clr_s = SRC_ZERO;
    if (wr_s && (address == ADDR_PENDING)) begin
      clr_s = clr_s | writedata[N_SRC-1:0];
    end else begin
      clr_s = clr_s;
    end
    if ((state_r == ST_REQ) && irq_ack) begin
      clr_s = clr_s | id_onehot_s;
    end else begin
      clr_s = clr_s;
    end
    pending_next_s = (pending_r & ~clr_s) | edge_r;
  end

  // Handshake FSM next-state and winner latch.
  always_comb begin
    state_next_s  = state_r;
    irq_id_next_s = irq_id;
    case (state_r)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_next_s  = ST_REQ;
          irq_id_next_s = lowest_index(eligible_s);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_next_s = ST_ACTIVE;
        end else if (!id_eligible_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_ACTIVE: begin
        if (wr_s && (address == ADDR_CTRL)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Register read mux over pre-update state.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_STATUS:  rd_s = pad32(sync2_r);
      ADDR_PENDING: rd_s = pad32(pending_r);
      ADDR_MASK:    rd_s = pad32(mask_r);
      ADDR_CTRL:    rd_s = {(state_r == ST_ACTIVE), 26'd0, irq_id};
      default:      rd_s = 32'd0;
    endcase
  end

  // Input synchroniser and registered rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= SRC_ZERO;
      sync2_r <= SRC_ZERO;
      prev_r  <= SRC_ZERO;
      edge_r  <= SRC_ZERO;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      edge_r  <= sync2_r & ~prev_r;
    end
  end

  // Pending and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= SRC_ZERO;
      mask_r    <= SRC_ZERO;
    end else begin
      pending_r <= pending_next_s;
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= writedata[N_SRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // FSM state and registered core-facing outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      irq_req  <= 1'b0;
      irq_id   <= 5'd0;
      readdata <= 32'd0;
    end else begin
      state_r  <= state_next_s;
      irq_req  <= (state_next_s == ST_REQ);
      irq_id   <= irq_id_next_s;
      readdata <= rd_s;
    end
  end

endmodule
